mask_op_sequencer: RTL and testbench

//  Executes RVV mask-register logical instructions (vmand/vmnand/vmandn/vmxor/vmor/vmnor/vmorn/vmxnor).

---
 rtl/mask_op_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_mask_op_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_op_sequencer.sv
// RVV mask-register logical op sequencer: streams vs1/vs2 packets out of the mask
// register file, applies vs2 <op> vs1 and writes the result to vd with byte enables.
module mask_op_sequencer #(
   parameter int DATA_WIDTH = 64,
   parameter int DW_B       = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH = 5,
   parameter int OFF_BITS   = 8,
   parameter int VL_BITS    = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_vd,
   input  logic [ADDR_WIDTH-1:0] cmd_vs1,
   input  logic [ADDR_WIDTH-1:0] cmd_vs2,
   input  logic [VL_BITS-1:0]    cmd_vl,
   output logic                  rf_rd_en_1,
   output logic [ADDR_WIDTH-1:0] rf_rd_addr_1,
   output logic [OFF_BITS-1:0]   rf_rd_off_1,
   input  logic [DATA_WIDTH-1:0] rf_rd_data_1,
   output logic                  rf_rd_en_2,
   output logic [ADDR_WIDTH-1:0] rf_rd_addr_2,
   output logic [OFF_BITS-1:0]   rf_rd_off_2,
   input  logic [DATA_WIDTH-1:0] rf_rd_data_2,
   output logic [DW_B-1:0]       rf_wr_en,
   output logic [ADDR_WIDTH-1:0] rf_wr_addr,
   output logic [OFF_BITS-1:0]   rf_wr_off,
   output logic [DATA_WIDTH-1:0] rf_wr_data,
   output logic                  busy,
   output logic                  done
);

   localparam int LOG_DW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [DATA_WIDTH-1:0] mask_op_f(input logic [2:0]            op,
                                                       input logic [DATA_WIDTH-1:0] vs2_d,
                                                       input logic [DATA_WIDTH-1:0] vs1_d);
      logic [DATA_WIDTH-1:0] res;
      case (op)
         3'b000:  res = vs2_d & ~vs1_d;
         3'b001:  res = vs2_d & vs1_d;
         3'b010:  res = vs2_d | vs1_d;
         3'b011:  res = vs2_d ^ vs1_d;
         3'b100:  res = vs2_d | ~vs1_d;
         3'b101:  res = ~(vs2_d & vs1_d);
         3'b110:  res = ~(vs2_d | vs1_d);
         3'b111:  res = ~(vs2_d ^ vs1_d);
         default: res = '0;
      endcase
      return res;
   endfunction

   // Byte enables of the final packet: a zero remainder means a full packet.
   function automatic logic [DW_B-1:0] last_en_f(input logic [VL_BITS-1:0] vl);
      logic [LOG_DW:0]  n_bytes;
      logic [DW_B-1:0]  en;
      n_bytes = ({1'b0, vl[LOG_DW-1:0]} + (LOG_DW+1)'(3'd7)) >> 32'd3;
      en = '0;
      for (int i = 0; i < DW_B; i++) begin
         if ((n_bytes == '0) || (i < int'(n_bytes))) en[i] = 1'b1;
         else                                       en[i] = 1'b0;
      end
      return en;
   endfunction

   state_t                  state_r, state_nxt_s;
   logic                    accept_s;
   logic [VL_BITS-1:0]      vl_m1_s;
   logic [OFF_BITS-1:0]     last_off_s;
   logic [2:0]              op_r;
   logic [ADDR_WIDTH-1:0]   vd_r;
   logic [OFF_BITS-1:0]     last_off_r;
   logic [DW_B-1:0]         last_en_r;
   logic                    rd_en_r;
   logic [ADDR_WIDTH-1:0]   rd_addr_1_r, rd_addr_2_r;
   logic [OFF_BITS-1:0]     rd_off_r;
   logic                    pend_r, pend_last_r;
   logic [OFF_BITS-1:0]     pend_off_r;
   logic [DW_B-1:0]         wr_en_r;
   logic [ADDR_WIDTH-1:0]   wr_addr_r;
   logic [OFF_BITS-1:0]     wr_off_r;
   logic [DATA_WIDTH-1:0]   wr_data_r;
   logic                    busy_r, done_r, cmd_ready_r;

   assign accept_s   = cmd_valid & cmd_ready_r & (state_r == ST_IDLE);
   assign vl_m1_s    = cmd_vl - VL_BITS'(1'b1);
   assign last_off_s = OFF_BITS'(vl_m1_s >> LOG_DW);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_nxt_s;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (cmd_vl == '0) state_nxt_s = ST_DRAIN;
               else              state_nxt_s = ST_READ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ: begin
            if (rd_off_r == last_off_r) state_nxt_s = ST_DRAIN;
            else                        state_nxt_s = ST_READ;
         end
         ST_DRAIN: state_nxt_s = ST_DONE;
         ST_DONE:  state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // Command latch, read issue, write pipeline and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r        <= 3'd0;
         vd_r        <= '0;
         last_off_r  <= '0;
         last_en_r   <= '0;
         rd_en_r     <= 1'b0;
         rd_addr_1_r <= '0;
         rd_addr_2_r <= '0;
         rd_off_r    <= '0;
         pend_r      <= 1'b0;
         pend_last_r <= 1'b0;
         pend_off_r  <= '0;
         wr_en_r     <= '0;
         wr_addr_r   <= '0;
         wr_off_r    <= '0;
         wr_data_r   <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         cmd_ready_r <= 1'b1;
      end else begin
         if (accept_s) begin
            op_r        <= cmd_op;
            vd_r        <= cmd_vd;
            last_off_r  <= last_off_s;
            last_en_r   <= last_en_f(cmd_vl);
            rd_addr_1_r <= cmd_vs1;
            rd_addr_2_r <= cmd_vs2;
            rd_en_r     <= (cmd_vl != '0);
            rd_off_r    <= '0;
            busy_r      <= 1'b1;
            cmd_ready_r <= 1'b0;
         end else if (state_r == ST_READ) begin
            if (rd_off_r == last_off_r) rd_en_r  <= 1'b0;
            else                        rd_off_r <= rd_off_r + OFF_BITS'(1'b1);
         end else if (state_r == ST_DONE) begin
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
         end

         // read data for the packet issued last cycle arrives now
         pend_r      <= rd_en_r;
         pend_off_r  <= rd_off_r;
         pend_last_r <= rd_en_r & (rd_off_r == last_off_r);

         if (pend_r) begin
            wr_en_r   <= pend_last_r ? last_en_r : {DW_B{1'b1}};
            wr_addr_r <= vd_r;
            wr_off_r  <= pend_off_r;
            wr_data_r <= mask_op_f(op_r, rf_rd_data_2, rf_rd_data_1);
         end else begin
            wr_en_r   <= '0;
         end

         done_r <= (state_r == ST_DRAIN);
      end
   end

   assign cmd_ready    = cmd_ready_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign rf_rd_en_1   = rd_en_r;
   assign rf_rd_en_2   = rd_en_r;
   assign rf_rd_addr_1 = rd_addr_1_r;
   assign rf_rd_addr_2 = rd_addr_2_r;
   assign rf_rd_off_1  = rd_off_r;
   assign rf_rd_off_2  = rd_off_r;
   assign rf_wr_en     = wr_en_r;
   assign rf_wr_addr   = wr_addr_r;
   assign rf_wr_off    = wr_off_r;
   assign rf_wr_data   = wr_data_r;

endmodule

// File: tb/tb_mask_op_sequencer.sv
// Scoreboard bench for mask_op_sequencer with a behavioural mask register file;
// a negedge monitor checks every write, read request and done pulse.
module tb_mask_op_sequencer;

   localparam int DW  = 64;
   localparam int DWB = 8;
   localparam int AW  = 5;
   localparam int OW  = 8;
   localparam int VLW = 15;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [2:0]     cmd_op = 3'd0;
   logic [AW-1:0]  cmd_vd = '0, cmd_vs1 = '0, cmd_vs2 = '0;
   logic [VLW-1:0] cmd_vl = '0;
   logic           rf_rd_en_1, rf_rd_en_2;
   logic [AW-1:0]  rf_rd_addr_1, rf_rd_addr_2;
   logic [OW-1:0]  rf_rd_off_1, rf_rd_off_2;
   logic [DW-1:0]  rf_rd_data_1, rf_rd_data_2;
   logic [DWB-1:0] rf_wr_en;
   logic [AW-1:0]  rf_wr_addr;
   logic [OW-1:0]  rf_wr_off;
   logic [DW-1:0]  rf_wr_data;
   logic           busy, done;

   always #5 clk = ~clk;

   mask_op_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vl(cmd_vl),
      .rf_rd_en_1(rf_rd_en_1), .rf_rd_addr_1(rf_rd_addr_1), .rf_rd_off_1(rf_rd_off_1),
      .rf_rd_data_1(rf_rd_data_1),
      .rf_rd_en_2(rf_rd_en_2), .rf_rd_addr_2(rf_rd_addr_2), .rf_rd_off_2(rf_rd_off_2),
      .rf_rd_data_2(rf_rd_data_2),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_off(rf_wr_off),
      .rf_wr_data(rf_wr_data), .busy(busy), .done(done)
   );

   typedef struct {
      logic [AW-1:0]  addr;
      logic [OW-1:0]  off;
      logic [DWB-1:0] en;
      logic [DW-1:0]  data;
   } wr_t;

   wr_t           wr_q[$];
   int            done_q[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            rd_cnt = 0;
   int            done_cnt = 0;
   int            exp_rd_off = 0;
   logic [AW-1:0] cur_vs1 = '0, cur_vs2 = '0;
   logic          done_prev = 1'b0;
   logic [DW-1:0] mem [0:31][0:255];

   function automatic logic [63:0] pat3(input int k);
      return {8{8'(k)}} ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   function automatic logic [63:0] pat4(input int k);
      return {4{16'(k * 40503)}} ^ 64'hFFFF_0000_5A5A_0F0F;
   endfunction

   function automatic logic [63:0] init_val(input int r, input int k);
      case (r)
         1:       return 64'hF0F0_F0F0_F0F0_F0F0;
         2:       return 64'hFFFF_FFFF_FFFF_FFFF;
         3:       return pat3(k);
         4:       return pat4(k);
         5:       return 64'hAAAA_AAAA_AAAA_AAAA;
         6:       return 64'hCCCC_CCCC_CCCC_CCCC;
         default: return 64'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Register file model: one-cycle read latency, byte-enabled write
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc == 0) begin
         for (int r = 0; r < 32; r++)
            for (int k = 0; k < 256; k++)
               mem[r][k] <= init_val(r, k);
      end else begin
         if (rf_rd_en_1) rf_rd_data_1 <= mem[rf_rd_addr_1][rf_rd_off_1];
         if (rf_rd_en_2) rf_rd_data_2 <= mem[rf_rd_addr_2][rf_rd_off_2];
         for (int b = 0; b < DWB; b++)
            if (rf_wr_en[b]) mem[rf_wr_addr][rf_wr_off][b*8 +: 8] <= rf_wr_data[b*8 +: 8];
      end
   end

   // Monitor: pops the scoreboard on every DUT write and done pulse
   always @(negedge clk) begin
      if (rst_n) begin
         if (rf_rd_en_1) begin
            rd_cnt++;
            chk("rd_addr_1", 64'(rf_rd_addr_1), 64'(cur_vs1));
            chk("rd_addr_2", 64'(rf_rd_addr_2), 64'(cur_vs2));
            chk("rd_en_2", 64'(rf_rd_en_2), 64'd1);
            chk("rd_off_1", 64'(rf_rd_off_1), 64'(exp_rd_off));
            chk("rd_off_2", 64'(rf_rd_off_2), 64'(exp_rd_off));
            exp_rd_off++;
         end
         if (rf_wr_en != '0) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_write_en", 64'(rf_wr_en), 64'd0);
            end else begin
               wr_t e;
               e = wr_q.pop_front();
               chk("wr_addr", 64'(rf_wr_addr), 64'(e.addr));
               chk("wr_off", 64'(rf_wr_off), 64'(e.off));
               chk("wr_en", 64'(rf_wr_en), 64'(e.en));
               chk("wr_data", rf_wr_data, e.data);
            end
         end
         if (done) begin
            done_cnt++;
            chk("ready_low_at_done", 64'(cmd_ready), 64'd0);
            if (done_q.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
            else                    chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
         end
         if (done_prev) chk("ready_after_done", 64'(cmd_ready), 64'd1);
         done_prev = done;
      end else begin
         done_prev = 1'b0;
      end
   end

   task automatic push_wr(input logic [AW-1:0] a, input int off, input logic [DWB-1:0] en,
                          input logic [DW-1:0] d);
      wr_t e;
      e.addr = a; e.off = OW'(off); e.en = en; e.data = d;
      wr_q.push_back(e);
   endtask

   task automatic issue(input logic [2:0] op, input logic [AW-1:0] vd, input logic [AW-1:0] vs1,
                        input logic [AW-1:0] vs2, input int vl);
      int to;
      @(negedge clk);
      to = 0;
      while (!cmd_ready && to < 200) begin
         @(negedge clk);
         to++;
      end
      if (!cmd_ready) chk("ready_timeout", 64'(cmd_ready), 64'd1);
      cur_vs1 = vs1;
      cur_vs2 = vs2;
      exp_rd_off = 0;
      done_q.push_back(cyc + (vl + 63) / 64 + 2);
      cmd_op = op; cmd_vd = vd; cmd_vs1 = vs1; cmd_vs2 = vs2; cmd_vl = VLW'(vl);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic check_busy();
      @(negedge clk);
      chk("ready_low_busy", 64'(cmd_ready), 64'd0);
      chk("busy_high", 64'(busy), 64'd1);
   endtask

   task automatic wait_idle();
      int to;
      to = 0;
      @(negedge clk);
      while ((busy || done_q.size() != 0 || wr_q.size() != 0) && to < 1000) begin
         @(negedge clk);
         to++;
      end
      chk("writes_drained", 64'(wr_q.size()), 64'd0);
      chk("done_seen", 64'(done_q.size()), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      @(negedge clk);
   endtask

   logic [63:0] op_exp [0:7];
   int          snap, to;

   initial begin
      op_exp[0] = 64'h4444_4444_4444_4444;
      op_exp[1] = 64'h8888_8888_8888_8888;
      op_exp[2] = 64'hEEEE_EEEE_EEEE_EEEE;
      op_exp[3] = 64'h6666_6666_6666_6666;
      op_exp[4] = 64'hDDDD_DDDD_DDDD_DDDD;
      op_exp[5] = 64'h7777_7777_7777_7777;
      op_exp[6] = 64'h1111_1111_1111_1111;
      op_exp[7] = 64'h9999_9999_9999_9999;

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rd_en", 64'(rf_rd_en_1), 64'd0);
      chk("rst_wr_en", 64'(rf_wr_en), 64'd0);
      chk("rst_wr_data", rf_wr_data, 64'd0);
      chk("rst_rd_addr", 64'(rf_rd_addr_1), 64'd0);
      rst_n = 1'b1;

      // vl=128 and: two full packets
      push_wr(5'd7, 0, 8'hFF, 64'hF0F0_F0F0_F0F0_F0F0);
      push_wr(5'd7, 1, 8'hFF, 64'hF0F0_F0F0_F0F0_F0F0);
      issue(3'b001, 5'd7, 5'd1, 5'd2, 128);
      check_busy();
      wait_idle();

      // vl=70 xor: last packet carries one byte
      push_wr(5'd8, 0, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F);
      push_wr(5'd8, 1, 8'h01, 64'h0F0F_0F0F_0F0F_0F0F);
      issue(3'b011, 5'd8, 5'd1, 5'd2, 70);
      wait_idle();

      // vl=0: no register file traffic, done one cycle after accept
      snap = rd_cnt;
      issue(3'b001, 5'd9, 5'd1, 5'd2, 0);
      wait_idle();
      chk("zero_vl_no_reads", 64'(rd_cnt), 64'(snap));

      // vd aliases vs1: each result must use the old vs1 contents
      for (int k = 0; k < 4; k++) push_wr(5'd3, k, 8'hFF, pat4(k) | ~pat3(k));
      issue(3'b100, 5'd3, 5'd3, 5'd4, 256);
      wait_idle();

      // every op on A=0xAA.., B=0xCC.. (vs1=A, vs2=B)
      for (int op = 0; op < 8; op++) begin
         push_wr(5'd12, 0, 8'hFF, op_exp[op]);
         issue(3'(op), 5'd12, 5'd5, 5'd6, 64);
         check_busy();
         wait_idle();
      end

      // vs1 == vs2
      push_wr(5'd14, 0, 8'hFF, 64'h0);
      push_wr(5'd14, 1, 8'h03, 64'h0);
      issue(3'b011, 5'd14, 5'd5, 5'd5, 73);
      wait_idle();

      // reset in the middle of a vl=512 operation
      for (int k = 0; k < 8; k++) push_wr(5'd13, k, 8'hFF, 64'h8888_8888_8888_8888);
      issue(3'b001, 5'd13, 5'd5, 5'd6, 512);
      to = 0;
      while (!(rf_rd_en_1 && rf_rd_off_1 == 8'd2) && to < 50) begin
         @(negedge clk);
         to++;
      end
      chk("reached_packet2", 64'(rf_rd_off_1), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("abort_rd_en", 64'(rf_rd_en_1), 64'd0);
      chk("abort_wr_en", 64'(rf_wr_en), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_ready", 64'(cmd_ready), 64'd1);
      chk("abort_wr_data", rf_wr_data, 64'd0);
      wr_q.delete();
      done_q.delete();
      snap = done_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt), 64'(snap));

      push_wr(5'd10, 0, 8'hFF, 64'hEEEE_EEEE_EEEE_EEEE);
      issue(3'b010, 5'd10, 5'd5, 5'd6, 64);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
